// File: rtl/spi_device_interface_if.sv
// Fabric-side bus of the SPI target: received bytes, frame markers and the
// valid/ready transmit source. The slave modport is the SPI endpoint.
interface spi_device_interface_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_first;
    logic       frame_start;
    logic       frame_end;
    logic       frame_partial;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx_underrun;

    modport slave (
        output rx_valid, rx_data, rx_first,
        output frame_start, frame_end, frame_partial,
        output tx_ready, tx_underrun,
        input  tx_valid, tx_data
    );

    modport master (
        input  rx_valid, rx_data, rx_first,
        input  frame_start, frame_end, frame_partial,
        input  tx_ready, tx_underrun,
        output tx_valid, tx_data
    );
endinterface

// File: rtl/spi_device_interface.sv
// Oversampled SPI mode-0 target endpoint running entirely on clk: pins are
// synchronized, edges detected, bytes shifted in on MOSI and out on MISO.
module spi_device_interface #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  TX_IDLE     = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  spi_sck,
    input  logic                  spi_cs_n,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  spi_miso_oe,
    spi_device_interface_if.slave bus
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [SYNC_STAGES-1:0] sck_sync_r;
    logic [SYNC_STAGES-1:0] cs_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic [SYNC_STAGES:0]   fill_r;
    logic                   sck_hist_r;
    logic                   cs_hist_r;
    logic                   armed_r;
    logic                   sck_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   sck_rise_s;
    logic                   sck_fall_s;
    logic                   cs_fall_s;
    logic                   cs_rise_s;

    logic                   start_s;
    logic                   end_s;
    logic                   load_s;
    logic                   rx_shift_en_s;
    logic                   byte_done_s;
    logic                   tx_shift_en_s;
    logic                   miso_upd_s;
    logic [7:0]             tx_load_s;

    logic [2:0]             bit_cnt_r;
    logic                   first_r;
    logic                   first_cap_r;
    logic [7:0]             tx_shift_r;
    logic                   miso_r;
    logic                   miso_oe_r;
    logic                   tx_underrun_r;
    logic [7:0]             rx_shift_r;
    logic                   byte_done_r;
    logic                   rx_valid_r;
    logic [7:0]             rx_data_r;
    logic                   rx_first_r;
    logic                   frame_start_r;
    logic                   frame_end_r;
    logic                   frame_partial_r;

    assign sck_s      = sck_sync_r[SYNC_STAGES-1];
    assign cs_s       = cs_sync_r[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync_r[SYNC_STAGES-1];
    assign sck_rise_s = sck_s & ~sck_hist_r;
    assign sck_fall_s = ~sck_s & sck_hist_r;
    assign cs_fall_s  = ~cs_s & cs_hist_r;
    assign cs_rise_s  = cs_s & ~cs_hist_r;
    assign tx_load_s  = bus.tx_valid ? bus.tx_data : TX_IDLE;

    // Pin synchronizers, edge history and a fill marker showing when the pipe holds real samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_r  <= '0;
            cs_sync_r   <= '1;
            mosi_sync_r <= '0;
            fill_r      <= '0;
            sck_hist_r  <= 1'b0;
            cs_hist_r   <= 1'b1;
        end else begin
            sck_sync_r  <= {sck_sync_r[SYNC_STAGES-2:0], spi_sck};
            cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spi_mosi};
            fill_r      <= {fill_r[SYNC_STAGES-1:0], 1'b1};
            sck_hist_r  <= sck_s;
            cs_hist_r   <= cs_s;
        end
    end

    // Frames may only start once CS has genuinely been seen high since reset,
    // so a CS already held low across reset release never looks like a frame start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_r <= 1'b0;
        end else if (fill_r[SYNC_STAGES] && cs_s && cs_hist_r) begin
            armed_r <= 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state and per-cycle datapath strobes
    always_comb begin
        state_nxt_s   = state_r;
        start_s       = 1'b0;
        end_s         = 1'b0;
        load_s        = 1'b0;
        rx_shift_en_s = 1'b0;
        byte_done_s   = 1'b0;
        tx_shift_en_s = 1'b0;
        miso_upd_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cs_fall_s && armed_r) begin
                    state_nxt_s = ST_ACTIVE;
                    start_s     = 1'b1;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                // CS release wins over any SCK edge seen in the same cycle
                if (cs_rise_s) begin
                    state_nxt_s = ST_IDLE;
                    end_s       = 1'b1;
                end else if (sck_rise_s) begin
                    rx_shift_en_s = 1'b1;
                    if (bit_cnt_r == 3'd7) begin
                        byte_done_s = 1'b1;
                        load_s      = 1'b1;
                    end else begin
                        tx_shift_en_s = 1'b1;
                    end
                end else if (sck_fall_s) begin
                    miso_upd_s = 1'b1;
                end else begin
                    state_nxt_s = ST_ACTIVE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Bit counter and first-byte-of-frame tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_r   <= 3'd0;
            first_r     <= 1'b0;
            first_cap_r <= 1'b0;
        end else if (start_s) begin
            bit_cnt_r <= 3'd0;
            first_r   <= 1'b1;
        end else if (end_s) begin
            bit_cnt_r <= 3'd0;
        end else if (byte_done_s) begin
            bit_cnt_r   <= 3'd0;
            first_r     <= 1'b0;
            first_cap_r <= first_r;
        end else if (rx_shift_en_s) begin
            bit_cnt_r <= bit_cnt_r + 3'd1;
        end
    end

    // Transmit shifter, MISO pin and output enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift_r    <= 8'h00;
            miso_r        <= 1'b0;
            miso_oe_r     <= 1'b0;
            tx_underrun_r <= 1'b0;
        end else begin
            tx_underrun_r <= load_s & ~bus.tx_valid;
            if (load_s) begin
                tx_shift_r <= tx_load_s;
            end else if (tx_shift_en_s) begin
                tx_shift_r <= {tx_shift_r[6:0], 1'b0};
            end
            // On CS fall the new MSB goes straight to the pin; later bits follow SCK falls
            if (start_s) begin
                miso_r <= tx_load_s[7];
            end else if (miso_upd_s) begin
                miso_r <= tx_shift_r[7];
            end
            if (start_s) begin
                miso_oe_r <= 1'b1;
            end else if (end_s) begin
                miso_oe_r <= 1'b0;
            end
        end
    end

    // Receive shifter, byte delivery and frame markers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_shift_r      <= 8'h00;
            byte_done_r     <= 1'b0;
            rx_valid_r      <= 1'b0;
            rx_data_r       <= 8'h00;
            rx_first_r      <= 1'b0;
            frame_start_r   <= 1'b0;
            frame_end_r     <= 1'b0;
            frame_partial_r <= 1'b0;
        end else begin
            if (rx_shift_en_s) begin
                rx_shift_r <= {rx_shift_r[6:0], mosi_s};
            end
            byte_done_r   <= byte_done_s;
            rx_valid_r    <= byte_done_r;
            frame_start_r <= start_s;
            frame_end_r   <= end_s;
            if (byte_done_r) begin
                rx_data_r  <= rx_shift_r;
                rx_first_r <= first_cap_r;
            end
            if (end_s) begin
                frame_partial_r <= (bit_cnt_r != 3'd0);
            end
        end
    end

    assign spi_miso          = miso_r;
    assign spi_miso_oe       = miso_oe_r;
    assign bus.rx_valid      = rx_valid_r;
    assign bus.rx_data       = rx_data_r;
    assign bus.rx_first      = rx_first_r;
    assign bus.frame_start   = frame_start_r;
    assign bus.frame_end     = frame_end_r;
    assign bus.frame_partial = frame_partial_r;
    // Ready must coincide with the consuming cycle, so it cannot be delayed a clock
    assign bus.tx_ready      = load_s & bus.tx_valid;
    assign bus.tx_underrun   = tx_underrun_r;

endmodule

// File: tb/tb_spi_device_interface.sv
// Bench for spi_device_interface: the bench acts as SPI host and transmit
// source, predicting every byte and pulse from the protocol rules.
module tb_spi_device_interface;
    localparam int         SYNC   = 2;
    localparam logic [7:0] IDLE_B = 8'h00;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic spi_sck = 1'b0;
    logic spi_cs_n = 1'b1;
    logic spi_mosi = 1'b0;
    logic spi_miso;
    logic spi_miso_oe;

    spi_device_interface_if bus ();

    spi_device_interface #(.SYNC_STAGES(SYNC), .TX_IDLE(IDLE_B)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi_sck     (spi_sck),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_rise = 0;
    logic tx_en = 1'b0;
    logic [7:0] tx_src_q [$];

    // Pulse log filled by the monitor; scenarios only read it
    logic [7:0] rx_d_q [$];
    logic       rx_f_q [$];
    int         rx_c_q [$];
    int fs_cnt = 0, fe_cnt = 0, rdy_cnt = 0, und_cnt = 0, bad_rdy = 0;
    logic last_partial = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.rx_valid) begin
            rx_d_q.push_back(bus.rx_data);
            rx_f_q.push_back(bus.rx_first);
            rx_c_q.push_back(cyc);
        end
        if (bus.tx_ready) rdy_cnt++;
        if (bus.tx_ready && !bus.tx_valid) bad_rdy++;
        if (bus.tx_underrun) und_cnt++;
        if (bus.frame_start) fs_cnt++;
        if (bus.frame_end) begin
            fe_cnt++;
            last_partial = bus.frame_partial;
        end
    end

    // Transmit source: offers the queue head, pops it when the DUT takes it
    initial begin
        logic take;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        forever begin
            @(negedge clk);
            take = bus.tx_ready;
            @(posedge clk);
            #1;
            if (take && tx_src_q.size() > 0) void'(tx_src_q.pop_front());
            bus.tx_valid = tx_en && (tx_src_q.size() > 0);
            bus.tx_data  = (tx_src_q.size() > 0) ? tx_src_q[0] : 8'($urandom);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic [7:0] b, input int nbits, input int half, output logic [7:0] got);
        got = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = b[7-i];
            wait_cyc(half);
            got[7-i] = spi_miso;
            spi_sck = 1'b1;
            last_rise = cyc;
            wait_cyc(half);
            spi_sck = 1'b0;
        end
    endtask

    // One frame: full bytes from mo, then tail extra bits, then CS release
    task automatic run_frame(input string tag, input logic [7:0] mo [$], input int tail, input int half);
        logic [7:0] exp_tx [$];
        logic [7:0] host_rd [$];
        int rise_c [$];
        logic [7:0] got;
        int nb, loads, exp_rdy, fs0, fe0, rdy0, und0, rx0;
        wait_cyc(2);
        nb = mo.size();
        // A load point fires at CS fall and after every completed byte, including the last
        loads = nb + 1;
        exp_rdy = 0;
        for (int k = 0; k < loads; k++) begin
            if (tx_en && k < tx_src_q.size()) begin
                exp_tx.push_back(tx_src_q[k]);
                exp_rdy++;
            end else begin
                exp_tx.push_back(IDLE_B);
            end
        end
        fs0 = fs_cnt; fe0 = fe_cnt; rdy0 = rdy_cnt; und0 = und_cnt; rx0 = rx_d_q.size();
        spi_cs_n = 1'b0;
        wait_cyc(10);
        check_eq({tag, "/oe"}, spi_miso_oe, 1);
        for (int k = 0; k < nb; k++) begin
            xfer(mo[k], 8, half, got);
            host_rd.push_back(got);
            rise_c.push_back(last_rise);
        end
        if (tail > 0) xfer(8'($urandom), tail, half, got);
        wait_cyc(half);
        spi_cs_n = 1'b1;
        wait_cyc(10);
        check_eq({tag, "/start"}, fs_cnt - fs0, 1);
        check_eq({tag, "/end"}, fe_cnt - fe0, 1);
        check_eq({tag, "/partial"}, last_partial, (tail != 0));
        check_eq({tag, "/oe_off"}, spi_miso_oe, 0);
        check_eq({tag, "/rx_count"}, rx_d_q.size() - rx0, nb);
        for (int k = 0; k < nb; k++) begin
            check_eq($sformatf("%s/miso%0d", tag, k), host_rd[k], exp_tx[k]);
            if (rx0 + k < rx_d_q.size()) begin
                check_eq($sformatf("%s/rx%0d", tag, k), rx_d_q[rx0+k], mo[k]);
                check_eq($sformatf("%s/first%0d", tag, k), rx_f_q[rx0+k], (k == 0));
                check_eq($sformatf("%s/lat%0d", tag, k), rx_c_q[rx0+k] - rise_c[k], SYNC + 2);
                if (k > 0 && rx0 + k - 1 < rx_c_q.size())
                    check_eq($sformatf("%s/gap%0d", tag, k), rx_c_q[rx0+k] - rx_c_q[rx0+k-1], 16 * half);
            end
        end
        check_eq({tag, "/ready"}, rdy_cnt - rdy0, exp_rdy);
        check_eq({tag, "/underrun"}, und_cnt - und0, loads - exp_rdy);
    endtask

    initial begin
        logic [7:0] mo [$];
        logic [7:0] got;
        int fs0, nb;

        wait_cyc(4);
        check_eq("reset/miso", spi_miso, 0);
        check_eq("reset/oe", spi_miso_oe, 0);
        check_eq("reset/rx_valid", bus.rx_valid, 0);
        check_eq("reset/rx_data", bus.rx_data, 0);
        check_eq("reset/rx_first", bus.rx_first, 0);
        check_eq("reset/pulses", {bus.frame_start, bus.frame_end, bus.tx_underrun, bus.tx_ready}, 0);
        rst_n = 1'b1;
        wait_cyc(10);

        tx_en = 1'b1;
        tx_src_q.push_back(8'h3C);
        mo = '{8'hA5};
        run_frame("single", mo, 0, 4);

        tx_src_q = '{8'h10, 8'h11, 8'h12, 8'h13};
        mo = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_frame("burst", mo, 0, 4);

        tx_en = 1'b0;
        mo = '{8'($urandom), 8'($urandom)};
        run_frame("underrun", mo, 0, 4);

        mo = '{};
        run_frame("partial", mo, 5, 4);
        mo = '{8'($urandom)};
        run_frame("after_partial", mo, 0, 4);

        // Reset in the middle of a frame with CS held low throughout
        spi_cs_n = 1'b0;
        wait_cyc(10);
        xfer(8'($urandom), 3, 4, got);
        rst_n = 1'b0;
        wait_cyc(2);
        check_eq("rst_mid/oe", spi_miso_oe, 0);
        check_eq("rst_mid/miso", spi_miso, 0);
        fs0 = fs_cnt;
        rst_n = 1'b1;
        wait_cyc(30);
        check_eq("rst_mid/no_start", fs_cnt - fs0, 0);
        check_eq("rst_mid/oe_idle", spi_miso_oe, 0);
        spi_cs_n = 1'b1;
        wait_cyc(10);
        mo = '{8'hC3};
        run_frame("rst_after", mo, 0, 4);

        tx_en = 1'b1;
        tx_src_q.delete();
        mo = '{};
        for (int k = 0; k < 16; k++) begin
            mo.push_back(8'($urandom));
            tx_src_q.push_back(8'($urandom));
        end
        run_frame("maxrate", mo, 0, 4);

        for (int r = 0; r < 4; r++) begin
            tx_en = 1'($urandom_range(0, 1));
            tx_src_q.delete();
            repeat ($urandom_range(0, 3)) tx_src_q.push_back(8'($urandom));
            nb = $urandom_range(1, 3);
            mo = '{};
            for (int k = 0; k < nb; k++) mo.push_back(8'($urandom));
            run_frame($sformatf("rand%0d", r), mo, $urandom_range(0, 7), $urandom_range(4, 6));
        end

        check_eq("ready_needs_valid", bad_rdy, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
